acc_seq_core: RTL and testbench



---
 rtl/acc_seq_pkg.sv | 8 +
 rtl/acc_seq_alu.sv | 41 ++++
 rtl/acc_seq_core.sv | 72 +++++++
 tb/tb_acc_seq_core.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: opcode and run-state types shared by the accumulator sequencer core and ALU
package acc_seq_pkg;
  localparam int OPC_W = 3;
  typedef enum logic [OPC_W-1:0] {
    OP_LDI, OP_ADD, OP_AND, OP_OR, OP_SUB, OP_XOR, OP_JNZ, OP_HLT
  } opcode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;
endpackage

// File: rtl/acc_seq_alu.sv
// acc_seq_alu: combinational ALU for acc_seq_core; SAT_ARITH_EN selects saturating ADD/SUB
module acc_seq_alu
  import acc_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 6
) (
  input  opcode_t           op,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);
  logic [DATA_W-1:0] ext, add_r, sub_r;
  logic [DATA_W:0]   sum, diff;
  assign ext  = DATA_W'(imm);
  assign sum  = {1'b0, acc} + {1'b0, ext};
  assign diff = {1'b0, acc} - {1'b0, ext};
`ifdef SAT_ARITH_EN
  assign add_r = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
  assign sub_r = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
  assign add_r = sum[DATA_W-1:0];
  assign sub_r = diff[DATA_W-1:0];
`endif
  always_comb begin
    result = acc;
    case (op)
      OP_LDI:  result = ext;
      OP_ADD:  result = add_r;
      OP_AND:  result = acc & ext;
      OP_OR:   result = acc | ext;
      OP_SUB:  result = sub_r;
      OP_XOR:  result = acc ^ ext;
      default: result = acc;
    endcase
  end
  assign zero  = result == '0;
  assign carry = (op == OP_SUB) ? diff[DATA_W] : sum[DATA_W];
endmodule

// File: rtl/acc_seq_core.sv
// acc_seq_core: accumulator execution core with loadable program RAM, one instruction per clock.
// Define SAT_ARITH_EN for saturating ADD/SUB (wraps otherwise).
module acc_seq_core
  import acc_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 6,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [ADDR_W-1:0]      prog_addr,
  input  logic [OPC_W+IMM_W-1:0] prog_data,
  output logic [DATA_W-1:0]      accumulator,
  output logic [ADDR_W-1:0]      pc,
  output logic                   busy,
  output logic                   halted,
  output logic                   zero_flag,
  output logic                   carry_flag
);
  logic [OPC_W+IMM_W-1:0] mem [DEPTH];
  logic [OPC_W+IMM_W-1:0] word;
  state_t            state, state_next;
  opcode_t           op;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] result;
  logic              alu_zero, alu_carry, taken, bad_target, stop, launch;
  assign word = mem[pc];
  assign op   = opcode_t'(word[OPC_W+IMM_W-1:IMM_W]);
  assign imm  = word[IMM_W-1:0];
  assign taken      = op == OP_JNZ && accumulator != '0;
  assign bad_target = taken && (imm >> ADDR_W) != '0;
  // Running off the last entry halts unless a legal jump redirects the PC.
  assign stop   = op == OP_HLT || bad_target || (&pc && !taken);
  assign launch = start && state != ST_RUN;
  acc_seq_alu #(.DATA_W(DATA_W), .IMM_W(IMM_W)) alu (
    .op(op), .imm(imm), .acc(accumulator),
    .result(result), .zero(alu_zero), .carry(alu_carry)
  );
  always_ff @(posedge clock)
    if (prog_we && state != ST_RUN) mem[prog_addr] <= prog_data;
  always_ff @(posedge clock)
    state <= reset ? ST_IDLE : state_next;
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_next = stop ? ST_HALT : ST_RUN;
      ST_HALT: state_next = start ? ST_RUN : ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end
  always_comb begin
    busy   = state == ST_RUN;
    halted = state == ST_HALT;
  end
  always_ff @(posedge clock)
    if (reset || launch) begin
      accumulator <= '0;
      pc          <= '0;
      zero_flag   <= 1'b0;
      carry_flag  <= 1'b0;
    end else if (state == ST_RUN) begin
      accumulator <= result;
      zero_flag   <= (op <= OP_XOR) ? alu_zero : zero_flag;
      carry_flag  <= (op == OP_ADD || op == OP_SUB) ? alu_carry : carry_flag;
      pc          <= stop ? pc : taken ? imm[ADDR_W-1:0] : pc + ADDR_W'(1);
    end
endmodule

// File: tb/tb_acc_seq_core.sv
// tb_acc_seq_core: scoreboard bench; a program-level reference model predicts every cycle of each run
module tb_acc_seq_core;
  localparam int D = 16;
  localparam int MAXV = 255;
`ifdef SAT_ARITH_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    int         cyc;
    logic [7:0] acc;
    logic [3:0] pc;
    logic       z, c, b, h;
  } obs_t;

  logic       clock = 0, reset = 1, start = 0, prog_we = 0;
  logic [3:0] prog_addr = 0;
  logic [8:0] prog_data = 0;
  logic [7:0] accumulator;
  logic [3:0] pc;
  logic       busy, halted, zero_flag, carry_flag;

  logic [8:0] img [D];
  logic [8:0] prog [D];
  obs_t q[$];
  obs_t e;
  int cyc = 0, total = 0, bad = 0, busy_cycles = 0;

  acc_seq_core #(.DATA_W(8), .IMM_W(6), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .accumulator(accumulator),
    .pc(pc), .busy(busy), .halted(halted), .zero_flag(zero_flag), .carry_flag(carry_flag)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (busy) busy_cycles++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.cyc != cyc || {accumulator, pc, zero_flag, carry_flag, busy, halted}
                      !== {e.acc, e.pc, e.z, e.c, e.b, e.h}) begin
        bad++;
        $display("FAIL obs cyc=%0d/%0d got acc=%0d pc=%0d z=%0b c=%0b busy=%0b halted=%0b need acc=%0d pc=%0d z=%0b c=%0b busy=%0b halted=%0b",
                 cyc, e.cyc, accumulator, pc, zero_flag, carry_flag, busy, halted,
                 e.acc, e.pc, e.z, e.c, e.b, e.h);
      end
    end
  end

  function automatic logic [8:0] ins(input int op, input int imm);
    return {op[2:0], imm[5:0]};
  endfunction

  task automatic push(input int t, input int a, input int p, input int z, input int c, input int b, input int h);
    obs_t o;
    o.cyc = t; o.acc = 8'(a); o.pc = 4'(p);
    o.z = z[0]; o.c = c[0]; o.b = b[0]; o.h = h[0];
    q.push_back(o);
  endtask

  // Executes the program image instruction by instruction and queues the expected state after each edge.
  task automatic push_run();
    int t, p, a, z, c, op, im, r, steps;
    bit h;
    t = cyc + 1; p = 0; a = 0; z = 0; c = 0; h = 0; steps = 0;
    push(t, a, p, z, c, 1, 0);
    while (!h && steps < 500) begin
      op = int'(img[p][8:6]);
      im = int'(img[p][5:0]);
      case (op)
        0: a = im;
        1: begin r = a + im; c = int'(r > MAXV); a = (r > MAXV) ? (SAT ? MAXV : r - MAXV - 1) : r; end
        2: a = a & im;
        3: a = a | im;
        4: begin r = a - im; c = int'(r < 0); a = (r < 0) ? (SAT ? 0 : r + MAXV + 1) : r; end
        5: a = a ^ im;
        default: ;
      endcase
      if (op <= 5) z = int'(a == 0);
      if (op == 7) h = 1;
      else if (op == 6 && a != 0) begin
        if (im >= D) h = 1; else p = im;
      end else if (p == D - 1) h = 1;
      else p++;
      t++; steps++;
      push(t, a, p, z, c, int'(!h), int'(h));
    end
  endtask

  task automatic load();
    for (int i = 0; i < D; i++) begin
      @(posedge clock); #1;
      prog_we = 1; prog_addr = 4'(i); prog_data = prog[i]; img[i] = prog[i];
    end
    @(posedge clock); #1;
    prog_we = 0;
  endtask

  task automatic fill(input logic [8:0] w);
    for (int i = 0; i < D; i++) prog[i] = w;
  endtask

  task automatic run();
    @(posedge clock); #1;
    start = 1;
    push_run();
    @(posedge clock); #1;
    start = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 400) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (q.size() > 0) begin
      bad++; total++;
      $display("FAIL drain timeout left=%0d need 0", q.size());
      q.delete();
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d need=%0d", name, act, exp);
    end
  endtask

  initial begin
    int b0;
    @(posedge clock); #1;
    push(cyc + 1, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    reset = 0;
    drain();

    fill(ins(7, 0));
    prog[0] = ins(0, 3); prog[1] = ins(1, 7); prog[2] = ins(2, 4);
    load(); run(); drain();
    check("t1_acc", int'(accumulator), 0);
    check("t1_zero", int'(zero_flag), 1);
    check("t1_pc", int'(pc), 3);
    check("t1_halted", int'(halted), 1);

    fill(ins(7, 0));
    prog[0] = ins(0, 5); prog[1] = ins(4, 1); prog[2] = ins(6, 1);
    load();
    b0 = busy_cycles;
    run(); drain();
    check("t2_run_cycles", busy_cycles - b0, 12);
    check("t2_acc", int'(accumulator), 0);
    check("t2_zero", int'(zero_flag), 1);

    fill(ins(7, 0));
    prog[0] = ins(0, 63);
    for (int i = 1; i < 5; i++) prog[i] = ins(1, 63);
    load(); run(); drain();
    check("t3_acc", int'(accumulator), SAT ? 255 : 59);
    check("t3_carry", int'(carry_flag), 1);

    fill(ins(1, 1));
    load(); run(); drain();
    check("t4_falloff_pc", int'(pc), 15);
    check("t4_falloff_halted", int'(halted), 1);
    check("t4_falloff_acc", int'(accumulator), 16);

    fill(ins(7, 0));
    prog[0] = ins(0, 1); prog[1] = ins(6, 20); prog[2] = ins(0, 9);
    load(); run(); drain();
    check("t4_badjump_pc", int'(pc), 1);
    check("t4_badjump_acc", int'(accumulator), 1);

    fill(ins(7, 0));
    prog[0] = ins(0, 5); prog[1] = ins(4, 1); prog[2] = ins(6, 1);
    load(); run();
    repeat (2) @(posedge clock);
    #1;
    prog_we = 1; prog_addr = 0; prog_data = ins(0, 2); start = 1;
    @(posedge clock); #1;
    prog_we = 0; start = 0;
    drain();
    run(); drain();
    check("t5_rerun_acc", int'(accumulator), 0);

    @(posedge clock); #1;
    prog_we = 1; prog_addr = 0; prog_data = ins(0, 2); img[0] = ins(0, 2); start = 1;
    push_run();
    @(posedge clock); #1;
    prog_we = 0; start = 0;
    drain();

    run();
    repeat (4) @(posedge clock);
    #1;
    reset = 1;
    q.delete();
    push(cyc + 1, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    reset = 0;
    drain();
    run(); drain();

    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < D; i++) begin
        int op;
        op = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 6));
        prog[i] = ins(op, (op == 6) ? int'($urandom_range(i + 1, 63)) : int'($urandom_range(0, 63)));
      end
      load(); run(); drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
